// File: rtl/seg7_decode.sv
// seg7_decode: reads back an active-low units/tens seven-segment pair and
// recovers the displayed value 0..15 once the pattern has been stable for
// STABLE_CYCLES clocks. Illegal glyph combinations are flagged on err.
// Optional: define SEG7_DECODE_SYNC_EN to put a 2-flop synchronizer ahead
// of the sample register (adds 2 cycles of latency).
module seg7_decode #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [6:0]  seg_units,
  input  logic [6:0]  seg_tens,
  output logic [15:0] onehot,
  output logic [3:0]  value,
  output logic        valid,
  output logic        locked,
  output logic        err,
  output logic        blank
);

  localparam int unsigned SW = 14;
  localparam int unsigned CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ACC = CW'(STABLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    LOCKED,
    ERROR,
    BLANKED
  } state_t;

  state_t        state;
  logic [SW-1:0] sample;
  logic [SW-1:0] din;
  logic [CW-1:0] cnt;
  logic          same;

  logic [6:0] u_glyph;
  logic [6:0] t_glyph;
  logic       u_ok;
  logic [3:0] u_val;
  logic       t_ok;
  logic       t_one;
  logic       dec_blank;
  logic       dec_legal;
  logic [3:0] dec_value;

`ifdef SEG7_DECODE_SYNC_EN
  logic [SW-1:0] sync1;
  logic [SW-1:0] sync2;

  // Two-flop synchronizer for asynchronous board-level segment buses
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {seg_tens, seg_units};
      sync2 <= sync1;
    end
  end

  assign din = sync2;
`else
  assign din = {seg_tens, seg_units};
`endif

  assign same = (din == sample);

  // Decode the registered sample: glyph lookup, legality and blank detection
  always_comb begin
    u_glyph = ~sample[6:0];
    t_glyph = ~sample[13:7];
    u_ok    = 1'b1;
    u_val   = 4'd0;
    t_ok    = 1'b1;
    t_one   = 1'b0;
    case (u_glyph)
      7'b1111110: u_val = 4'd0;
      7'b0110000: u_val = 4'd1;
      7'b1101101: u_val = 4'd2;
      7'b1111001: u_val = 4'd3;
      7'b0110011: u_val = 4'd4;
      7'b1011011: u_val = 4'd5;
      7'b1011111: u_val = 4'd6;
      7'b1110000: u_val = 4'd7;
      7'b1111111: u_val = 4'd8;
      7'b1111011: u_val = 4'd9;
      default:    u_ok  = 1'b0;
    endcase
    case (t_glyph)
      7'b1000000: t_one = 1'b0;
      7'b1100000: t_one = 1'b1;
      default:    t_ok  = 1'b0;
    endcase
    dec_blank = (u_glyph == 7'd0) && (t_glyph == 7'd0);
    dec_legal = u_ok && t_ok && !(t_one && (u_val > 4'd5));
    dec_value = t_one ? 4'(4'd10 + u_val) : u_val;
  end

  // Sample register, stability counter, state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sample <= '1;
      cnt    <= '0;
      onehot <= '0;
      value  <= '0;
      valid  <= 1'b0;
      locked <= 1'b0;
      err    <= 1'b0;
      blank  <= 1'b0;
    end else begin
      sample <= din;
      if (!same) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= CW'(cnt + 1'b1);
      end
      valid <= 1'b0;

      if (!en) begin
        state  <= IDLE;
        locked <= 1'b0;
        err    <= 1'b0;
        blank  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= SETTLE;
          end
          SETTLE: begin
            // A change landing on the acceptance edge wins over acceptance
            if (same && (cnt >= CNT_ACC)) begin
              if (dec_blank) begin
                state  <= BLANKED;
                blank  <= 1'b1;
                onehot <= '0;
                value  <= '0;
              end else if (dec_legal) begin
                state  <= LOCKED;
                locked <= 1'b1;
                valid  <= 1'b1;
                value  <= dec_value;
                onehot <= 16'(16'd1 << dec_value);
              end else begin
                state <= ERROR;
                err   <= 1'b1;
              end
            end
          end
          default: begin
            if (!same) begin
              state  <= SETTLE;
              locked <= 1'b0;
              err    <= 1'b0;
              blank  <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_decode.sv
// Bench for seg7_decode: directed scenarios with a scoreboard of expected
// accepted values, popped whenever the DUT pulses valid.
module tb_seg7_decode;

  localparam int unsigned S = 4;
`ifdef SEG7_DECODE_SYNC_EN
  localparam int unsigned E = 2;
`else
  localparam int unsigned E = 0;
`endif
  // Edges from driving a fresh pattern to the acceptance edge
  localparam int unsigned ACC = S + 1 + E;

  // Active-low glyphs
  localparam logic [6:0] T0 = 7'h3F;
  localparam logic [6:0] T1 = 7'h1F;
  localparam logic [6:0] U2 = 7'h12;
  localparam logic [6:0] U3 = 7'h06;
  localparam logic [6:0] U4 = 7'h4C;
  localparam logic [6:0] U5 = 7'h24;
  localparam logic [6:0] U7 = 7'h0F;
  localparam logic [6:0] U9 = 7'h04;
  localparam logic [6:0] OFF = 7'h7F;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [6:0]  seg_units;
  logic [6:0]  seg_tens;
  logic [15:0] onehot;
  logic [3:0]  value;
  logic        valid;
  logic        locked;
  logic        err;
  logic        blank;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q[$];

  seg7_decode #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .en(en),
    .seg_units(seg_units), .seg_tens(seg_tens),
    .onehot(onehot), .value(value), .valid(valid),
    .locked(locked), .err(err), .blank(blank)
  );

  always #5 clk = ~clk;

  // Scoreboard: every valid pulse must match the next expected value
  always @(negedge clk) begin
    if (!rst && valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_valid value=%0d onehot=%h", value, onehot);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (value !== e || onehot !== (16'd1 << e)) begin
          failures++;
          $display("FAIL sb_value got=%0d/%h exp=%0d/%h", value, onehot, e, 16'd1 << e);
        end
      end
    end
    if (!rst && locked && err) begin
      checks++;
      failures++;
      $display("FAIL locked_err_overlap locked=%b err=%b exp=not both", locked, err);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] t, input logic [6:0] u);
    seg_tens  = t;
    seg_units = u;
  endtask

  // Advance n cycles, returning number of valid pulses seen
  task automatic count_valid(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      tick(1);
      if (valid === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; drive(OFF, OFF);
    tick(2);
    checks++;
    if ({onehot, value, valid, locked, err, blank} !== 24'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {onehot, value, valid, locked, err, blank});
    end
  endtask

  task automatic test_lock7();
    int p;
    exp_q.push_back(4'd7);
    drive(T0, U7);
    rst = 1'b0;
    tick(ACC - 1);
    checks++;
    if (valid !== 1'b0 || locked !== 1'b0) begin
      failures++;
      $display("FAIL lock7_early valid=%b locked=%b exp=0/0", valid, locked);
    end
    tick(1);
    checks++;
    if (valid !== 1'b1 || locked !== 1'b1 || value !== 4'd7 || onehot !== 16'h0080) begin
      failures++;
      $display("FAIL lock7_accept valid=%b locked=%b value=%0d onehot=%h exp=1/1/7/0080",
               valid, locked, value, onehot);
    end
    count_valid(10, p);
    checks++;
    if (p != 0 || locked !== 1'b1) begin
      failures++;
      $display("FAIL lock7_hold pulses=%0d locked=%b exp=0/1", p, locked);
    end
  endtask

  task automatic test_lock15();
    exp_q.push_back(4'd15);
    drive(T1, U5);
    tick(ACC - 1);
    checks++;
    if (locked !== 1'b0 || onehot !== 16'h0080 || value !== 4'd7) begin
      failures++;
      $display("FAIL lock15_settle locked=%b onehot=%h value=%0d exp=0/0080/7", locked, onehot, value);
    end
    tick(1);
    checks++;
    if (valid !== 1'b1 || value !== 4'd15 || onehot !== 16'h8000) begin
      failures++;
      $display("FAIL lock15_accept valid=%b value=%0d onehot=%h exp=1/15/8000", valid, value, onehot);
    end
  endtask

  task automatic test_toggle();
    int bad = 0;
    logic ph = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) begin
        drive(T0, ph ? U4 : U3);
        ph = ~ph;
      end
      tick(1);
      if (valid !== 1'b0 || locked !== 1'b0 || err !== 1'b0 || blank !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL toggle_settle bad_cycles=%0d exp=0", bad);
    end
    checks++;
    if (onehot !== 16'h8000 || value !== 4'd15) begin
      failures++;
      $display("FAIL toggle_hold onehot=%h value=%0d exp=8000/15", onehot, value);
    end
  endtask

  task automatic test_error();
    drive(T1, U9);
    tick(ACC - 1);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL error_early err=%b exp=0", err);
    end
    tick(1);
    checks++;
    if (err !== 1'b1 || locked !== 1'b0 || valid !== 1'b0 || onehot !== 16'h8000) begin
      failures++;
      $display("FAIL error_accept err=%b locked=%b valid=%b onehot=%h exp=1/0/0/8000",
               err, locked, valid, onehot);
    end
  endtask

  task automatic test_blank();
    drive(OFF, OFF);
    tick(ACC);
    checks++;
    if (blank !== 1'b1 || onehot !== 16'h0 || value !== 4'd0 || err !== 1'b0 || locked !== 1'b0) begin
      failures++;
      $display("FAIL blank_accept blank=%b onehot=%h value=%0d err=%b locked=%b exp=1/0000/0/0/0",
               blank, onehot, value, err, locked);
    end
    // Only one digit blank is illegal
    drive(T0, OFF);
    tick(ACC);
    checks++;
    if (err !== 1'b1 || blank !== 1'b0) begin
      failures++;
      $display("FAIL half_blank err=%b blank=%b exp=1/0", err, blank);
    end
  endtask

  task automatic test_back_to_back();
    drive(T0, U3);
    tick(ACC - 1);
    exp_q.push_back(4'd12);
    drive(T1, U2);
    tick(1);
    checks++;
    if (valid !== 1'b0 || locked !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_change_wins valid=%b locked=%b err=%b exp=0/0/0", valid, locked, err);
    end
    tick(ACC - 1);
    checks++;
    if (valid !== 1'b1 || value !== 4'd12 || onehot !== 16'h1000) begin
      failures++;
      $display("FAIL b2b_accept valid=%b value=%0d onehot=%h exp=1/12/1000", valid, value, onehot);
    end
  endtask

  task automatic test_rst_relock();
    int n;
    exp_q.push_back(4'd2);
    drive(T0, U2);
    tick(ACC);
    checks++;
    if (valid !== 1'b1 || value !== 4'd2) begin
      failures++;
      $display("FAIL relock_first valid=%b value=%0d exp=1/2", valid, value);
    end
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if ({onehot, value, valid, locked, err, blank} !== 24'd0) begin
      failures++;
      $display("FAIL relock_reset got=%h exp=0", {onehot, value, valid, locked, err, blank});
    end
    exp_q.push_back(4'd2);
    tick(ACC - 1);
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL relock_early valid=%b exp=0", valid);
    end
    tick(1);
    checks++;
    if (valid !== 1'b1 || value !== 4'd2 || onehot !== 16'h0004) begin
      failures++;
      $display("FAIL relock_accept valid=%b value=%0d onehot=%h exp=1/2/0004", valid, value, onehot);
    end
    // en dropped mid-SETTLE holds off acceptance until it returns
    drive(T0, U7);
    tick(2);
    en = 1'b0;
    count_valid(ACC + 4, n);
    checks++;
    if (n != 0 || locked !== 1'b0 || value !== 4'd2) begin
      failures++;
      $display("FAIL en_low pulses=%0d locked=%b value=%0d exp=0/0/2", n, locked, value);
    end
    exp_q.push_back(4'd7);
    en = 1'b1;
    n = 0;
    while (valid !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    checks++;
    if (valid !== 1'b1 || value !== 4'd7 || n < 2) begin
      failures++;
      $display("FAIL en_return valid=%b value=%0d cycles=%0d exp=1/7/>=2", valid, value, n);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; seg_units = OFF; seg_tens = OFF;
    test_reset();
    test_lock7();
    test_lock15();
    test_toggle();
    test_error();
    test_blank();
    test_back_to_back();
    test_rst_relock();
    tick(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover remaining=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
